// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared RV32 register-file constants and types.
// Provides XLEN, REG_ADDR_W, NUM_REGS, reg_addr_t and xlen_t.
package reg_bank_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one combinational register-file read port.
// Ports: i_rst, i_addr (read addr), i_stored (array word at i_addr),
//   i_we/i_wa/i_wd (write port, for bypass), o_rd (read data).
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_stored,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd
);

  logic w_hit;
  logic w_zero;

  assign w_hit  = (BYPASS != 0) && i_we && !i_rst
                  && (i_wa == i_addr);
  assign w_zero = (ZERO_REG != 0) && (i_addr == '0);

  // Zero-register mask and reset override the bypass.
  always_comb begin
    o_rd = i_stored;
    if (w_hit)
      o_rd = i_wd;
    if (w_zero || i_rst)
      o_rd = '0;
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: 2-read / 1-write register file, async active-high reset.
// Ports: clk, rst, a1/a2 (read addrs), a3/wd3/we (write), rd1/rd2.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wen;

  // x0 is never written when it is hardwired.
  assign w_wen = we && !((ZERO_REG != 0) && (a3 == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[a3] <= wd3;
    end
  end

  reg_bank_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rd1 (
    .i_rst    (rst),
    .i_addr   (a1),
    .i_stored (r_regs[a1]),
    .i_we     (we),
    .i_wa     (a3),
    .i_wd     (wd3),
    .o_rd     (rd1)
  );

  reg_bank_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rd2 (
    .i_rst    (rst),
    .i_addr   (a2),
    .i_stored (r_regs[a2]),
    .i_we     (we),
    .i_wa     (a3),
    .i_wd     (wd3),
    .o_rd     (rd2)
  );

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: checks reg_bank (BYPASS=0 and BYPASS=1 instances)
// against an array model with directed and random steps.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we;
  logic [31:0] d0_rd1, d0_rd2, d1_rd1, d1_rd2;

  int ncomp = 0;
  int nfail = 0;

  bit [31:0] m [32];

  always #5 clk = ~clk;

  reg_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut0 (
    .clk (clk), .rst (rst),
    .a1  (a1),  .a2  (a2),  .a3 (a3),
    .wd3 (wd3), .we  (we),
    .rd1 (d0_rd1), .rd2 (d0_rd2)
  );

  reg_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut1 (
    .clk (clk), .rst (rst),
    .a1  (a1),  .a2  (a2),  .a3 (a3),
    .wd3 (wd3), .we  (we),
    .rd1 (d1_rd1), .rd2 (d1_rd2)
  );

  function automatic logic [31:0] exp_rd(bit byp, logic [4:0] a);
    if (rst)                    return 32'h0;
    if (a == 5'd0)              return 32'h0;
    if (byp && we && a == a3)   return wd3;
    return m[a];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, "/d0.rd1"}, d0_rd1, exp_rd(0, a1));
    chk({tag, "/d0.rd2"}, d0_rd2, exp_rd(0, a2));
    chk({tag, "/d1.rd1"}, d1_rd1, exp_rd(1, a1));
    chk({tag, "/d1.rd2"}, d1_rd2, exp_rd(1, a2));
  endtask

  task automatic edge1();
    @(posedge clk);
    if (rst)
      foreach (m[i]) m[i] = 0;
    else if (we && a3 != 5'd0)
      m[a3] = wd3;
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    we = 1'b1; a3 = a; wd3 = d;
    edge1();
    we = 1'b0;
  endtask

  initial begin
    foreach (m[i]) m[i] = $urandom;
    rst = 1'b1; we = 1'b0;
    a1 = 5'd0; a2 = 5'd1; a3 = 5'd0; wd3 = 32'h0;
    #1;
    foreach (m[i]) m[i] = 0;
    chk_all("in_reset");
    edge1();
    edge1();
    rst = 1'b0;
    edge1();
    chk("rst_rd1", d0_rd1, 32'h0);
    chk("rst_rd2", d0_rd2, 32'h0);

    wr(5'd0, 32'hA5A5A5A5);
    a1 = 5'd0; #1;
    chk("x0_d0", d0_rd1, 32'h0);
    chk("x0_d1", d1_rd1, 32'h0);

    wr(5'd1, 32'hDEADBEEF);
    wr(5'd2, 32'hFFFFFFFF);
    a1 = 5'd1; a2 = 5'd2; #1;
    chk("dual_rd1", d0_rd1, 32'hDEADBEEF);
    chk("dual_rd2", d0_rd2, 32'hFFFFFFFF);
    a2 = 5'd1; #1;
    chk("same_rd1", d0_rd1, 32'hDEADBEEF);
    chk("same_rd2", d0_rd2, 32'hDEADBEEF);

    we = 1'b0; a3 = 5'd2; wd3 = 32'hF6FA5F0F;
    edge1();
    a2 = 5'd2; #1;
    chk("we0_rd2", d0_rd2, 32'hFFFFFFFF);

    a1 = 5'd3; a3 = 5'd3; we = 1'b1; wd3 = 32'hCAFEF00D; #1;
    chk("rdw_pre_b0", d0_rd1, 32'h0);
    chk("rdw_pre_b1", d1_rd1, 32'hCAFEF00D);
    edge1();
    chk("rdw_post_b0", d0_rd1, 32'hCAFEF00D);
    chk("rdw_post_b1", d1_rd1, 32'hCAFEF00D);
    a1 = 5'd0; a3 = 5'd0; wd3 = 32'h13579BDF; #1;
    chk("byp_x0", d1_rd1, 32'h0);
    we = 1'b0;

    for (int i = 1; i < 32; i++)
      wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i); #1;
      chk("sweep_rd1", d0_rd1, 32'(i) * 32'h01010101);
      chk("sweep_rd2", d0_rd2, 32'(31 - i) * 32'h01010101);
      chk_all("sweep");
    end

    for (int n = 0; n < 300; n++) begin
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      a3 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      wd3 = $urandom;
      we = 1'($urandom_range(0, 1));
      #1;
      chk_all("rand");
      edge1();
      we = 1'b0; #1;
      chk_all("rand_post");
    end

    wr(5'd5, 32'h12345678);
    a1 = 5'd5; a2 = 5'd5; #1;
    chk("x5_pre_rst", d0_rd1, 32'h12345678);
    we = 1'b1; a3 = 5'd5; wd3 = 32'h0BADF00D;
    rst = 1'b1; #1;
    foreach (m[i]) m[i] = 0;
    chk("async_rst_d0", d0_rd1, 32'h0);
    chk("async_rst_d1", d1_rd2, 32'h0);
    chk_all("async_rst");
    edge1();
    chk_all("rst_blk_wr");
    rst = 1'b0; we = 1'b0; #1;
    chk_all("rst_rel");
    a1 = 5'd1; a2 = 5'd31; #1;
    chk("cleared_x1", d0_rd1, 32'h0);
    chk("cleared_x31", d1_rd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
